// File: rtl/key_label_renderer.sv
// key_label_renderer: three-stage pixel pipeline that overlays the 13 piano-key
// letter sprites. Stage 1 hit-tests the draw position and drives the shared
// sprite ROM address, stage 2 picks the palette index of the matching ROM,
// stage 3 maps it to RGB.
// Optional feature macro: KEY_LABEL_HILITE_EN -- when defined, keys that are
// held or were released within the last HOLD_FRAMES frames render with a
// red-tinted highlight palette; when undefined, every label uses the normal
// palette and key_pressed / frame_start are ignored.
module key_label_renderer (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank_n,
  input  logic        frame_start,
  input  logic [12:0] key_pressed,
  output logic [18:0] rom_addr,
  input  logic [51:0] rom_data,
  output logic        label_hit,
  output logic [7:0]  Red,
  output logic [7:0]  Green,
  output logic [7:0]  Blue
);

  localparam int unsigned NUM_KEYS    = 13;
  localparam int unsigned LABEL_W     = 26;
  localparam int unsigned LABEL_H     = 33;
  localparam int unsigned X0          = 48;
  localparam int unsigned PITCH       = 40;
  localparam int unsigned WHITE_Y     = 400;
  localparam int unsigned BLACK_Y     = 340;
  localparam int unsigned HOLD_FRAMES = 8;
  localparam int unsigned COORD_W     = 10;
  localparam int unsigned ADDR_W      = 19;
  localparam int unsigned KEY_W       = 4;
  localparam int unsigned IDX_W       = 4;
  localparam int unsigned HOLD_W      = 4;
  localparam int unsigned COLOR_W     = 8;
  localparam logic [NUM_KEYS-1:0] BLACK_MASK = 13'b0_0101_0100_1010;

  // Stage 1 hit-test results
  logic               hit_c;
  logic [KEY_W-1:0]   key_c;
  logic [ADDR_W-1:0]  addr_c;
  logic [COORD_W-1:0] lx;
  logic [COORD_W-1:0] ly;

  logic               s1_hit;
  logic [KEY_W-1:0]   s1_key;

  // Stage 2 palette index selection
  logic [IDX_W-1:0]   idx_c;
  logic               s2_hit;
  logic [IDX_W-1:0]   s2_idx;

  // Normal palette replicates the nibble into a byte (idx * 0x11)
  logic [COLOR_W-1:0] grey_c;

`ifdef KEY_LABEL_HILITE_EN
  logic [NUM_KEYS-1:0] prev_pressed;
  logic [HOLD_W-1:0]   hold_cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] highlight_c;
  logic                hl_c;
  logic                s2_hl;
`else
  logic unused_hilite_inputs;
  assign unused_hilite_inputs = ^{key_pressed, frame_start};
`endif

  // Hit test against every label box; scanning high to low lets the lowest key win
  always_comb begin
    hit_c  = 1'b0;
    key_c  = '0;
    addr_c = '0;
    lx     = '0;
    ly     = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      lx = COORD_W'(X0 + 32'(k) * PITCH);
      ly = BLACK_MASK[k] ? COORD_W'(BLACK_Y) : COORD_W'(WHITE_Y);
      if (blank_n &&
          (DrawX >= lx) && (DrawX < lx + COORD_W'(LABEL_W)) &&
          (DrawY >= ly) && (DrawY < ly + COORD_W'(LABEL_H))) begin
        hit_c  = 1'b1;
        key_c  = KEY_W'(k);
        addr_c = ADDR_W'(DrawY - ly) * ADDR_W'(LABEL_W) + ADDR_W'(DrawX - lx);
      end
    end
  end

  // Stage 1 register: ROM address and which key owns the pixel
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_hit   <= 1'b0;
      s1_key   <= '0;
      rom_addr <= '0;
    end else begin
      s1_hit   <= hit_c;
      s1_key   <= key_c;
      rom_addr <= addr_c;
    end
  end

  // Pick the nibble of the ROM that belongs to the stage-1 key
  always_comb begin
    idx_c = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (s1_key == KEY_W'(k)) begin
        idx_c = rom_data[4*k +: 4];
      end
    end
  end

`ifdef KEY_LABEL_HILITE_EN
  // A key is highlighted while held or while its hold counter is still running
  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      highlight_c[k] = key_pressed[k] | (hold_cnt[k] != '0);
    end
  end

  // Highlight flag of the stage-1 key
  always_comb begin
    hl_c = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (s1_key == KEY_W'(k)) begin
        hl_c = highlight_c[k];
      end
    end
  end

  // Press edge reloads the hold counter; released keys count down once per frame
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      prev_pressed <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        hold_cnt[k] <= '0;
      end
    end else begin
      prev_pressed <= key_pressed;
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (key_pressed[k] && !prev_pressed[k]) begin
          hold_cnt[k] <= HOLD_W'(HOLD_FRAMES);
        end else if (frame_start && (hold_cnt[k] != '0) && !key_pressed[k]) begin
          hold_cnt[k] <= hold_cnt[k] - HOLD_W'(1);
        end
      end
    end
  end
`endif

  // Stage 2 register: palette index, opacity and highlight
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s2_hit <= 1'b0;
      s2_idx <= '0;
`ifdef KEY_LABEL_HILITE_EN
      s2_hl  <= 1'b0;
`endif
    end else begin
      s2_hit <= s1_hit && (idx_c != '0);
      s2_idx <= idx_c;
`ifdef KEY_LABEL_HILITE_EN
      s2_hl  <= hl_c;
`endif
    end
  end

  assign grey_c = {s2_idx, s2_idx};

  // Stage 3 register: palette to RGB, transparent pixels drive black
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      label_hit <= 1'b0;
      Red       <= '0;
      Green     <= '0;
      Blue      <= '0;
    end else if (!s2_hit) begin
      label_hit <= 1'b0;
      Red       <= '0;
      Green     <= '0;
      Blue      <= '0;
    end else begin
      label_hit <= 1'b1;
`ifdef KEY_LABEL_HILITE_EN
      if (s2_hl) begin
        Red   <= 8'hFF;
        Green <= grey_c >> 1;
        Blue  <= grey_c >> 1;
      end else begin
        Red   <= grey_c;
        Green <= grey_c;
        Blue  <= grey_c;
      end
`else
      Red   <= grey_c;
      Green <= grey_c;
      Blue  <= grey_c;
`endif
    end
  end

endmodule

// File: tb/tb_key_label_renderer.sv
// tb_key_label_renderer: random pixel stream against a behavioural model of the
// label renderer, plus directed literal checks of the key scenarios.
module tb_key_label_renderer;

  localparam int NK    = 13;
  localparam int LW    = 26;
  localparam int LH    = 33;
  localparam int X0    = 48;
  localparam int PITCH = 40;
  localparam int WY    = 400;
  localparam int BY    = 340;
  localparam int HOLD  = 8;
  localparam int DEPTH = 858;
  localparam logic [12:0] BMASK = 13'b0_0101_0100_1010;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        blank_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [12:0] key_pressed = '0;
  logic [18:0] rom_addr;
  logic [51:0] rom_data;
  logic        label_hit;
  logic [7:0]  Red, Green, Blue;

  logic [3:0] mem [NK][DEPTH];

  int errors = 0;
  int checks = 0;

  // Model state
  int m1_hit, m1_key, m1_addr;
  int m2_hit, m2_idx, m2_hl;
  int e_hit, e_r, e_g, e_b;
  int hold [NK];
  bit prev [NK];

  key_label_renderer dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank_n(blank_n), .frame_start(frame_start), .key_pressed(key_pressed),
    .rom_addr(rom_addr), .rom_data(rom_data), .label_hit(label_hit),
    .Red(Red), .Green(Green), .Blue(Blue)
  );

  always #5 Clk = ~Clk;

  // Combinational letter ROMs
  always_comb begin
    rom_data = '0;
    for (int k = 0; k < NK; k++) begin
      if (rom_addr < 19'(DEPTH)) rom_data[4*k +: 4] = mem[k][rom_addr];
    end
  end

  function automatic int lab_x(int k);
    return X0 + k * PITCH;
  endfunction

  function automatic int lab_y(int k);
    logic [12:0] m;
    m = BMASK;
    return m[k] ? BY : WY;
  endfunction

  // One pixel clock of the reference: outputs from last cycle's ROM read, etc.
  task model_step();
    int v, idx, x, y;
    if (!Reset_n) begin
      m1_hit = 0; m1_key = 0; m1_addr = 0;
      m2_hit = 0; m2_idx = 0; m2_hl = 0;
      e_hit = 0; e_r = 0; e_g = 0; e_b = 0;
      for (int k = 0; k < NK; k++) begin hold[k] = 0; prev[k] = 0; end
    end else begin
      v = m2_idx * 17;
      e_hit = m2_hit;
      if (!m2_hit) begin e_r = 0; e_g = 0; e_b = 0; end
      else if (m2_hl != 0) begin e_r = 255; e_g = v / 2; e_b = v / 2; end
      else begin e_r = v; e_g = v; e_b = v; end

      idx = int'(mem[m1_key][m1_addr]);
      m2_idx = idx;
      m2_hit = (m1_hit != 0 && idx != 0) ? 1 : 0;
`ifdef KEY_LABEL_HILITE_EN
      m2_hl = (key_pressed[m1_key] || hold[m1_key] != 0) ? 1 : 0;
`else
      m2_hl = 0;
`endif

      x = int'(DrawX); y = int'(DrawY);
      m1_hit = 0; m1_key = 0; m1_addr = 0;
      if (blank_n) begin
        for (int k = 0; k < NK; k++) begin
          if (m1_hit == 0 && x >= lab_x(k) && x < lab_x(k) + LW &&
              y >= lab_y(k) && y < lab_y(k) + LH) begin
            m1_hit = 1; m1_key = k;
            m1_addr = (y - lab_y(k)) * LW + (x - lab_x(k));
          end
        end
      end

      for (int k = 0; k < NK; k++) begin
        if (key_pressed[k] && !prev[k]) hold[k] = HOLD;
        else if (frame_start && hold[k] > 0 && !key_pressed[k]) hold[k] = hold[k] - 1;
        prev[k] = key_pressed[k];
      end
    end
  endtask

  always @(posedge Clk or negedge Reset_n) model_step();

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("rom_addr", int'(rom_addr), m1_addr);
    chk("label_hit", int'(label_hit), e_hit);
    chk("red", int'(Red), e_r);
    chk("green", int'(Green), e_g);
    chk("blue", int'(Blue), e_b);
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
    compare_all();
  endtask

  task automatic set_px(int x, int y, bit b);
    DrawX = 10'(x); DrawY = 10'(y); blank_n = b;
  endtask

  task automatic frame();
    frame_start = 1'b1; tick();
    frame_start = 1'b0; tick();
  endtask

  // Key-2 pixel (130,401) -> address 28 holding idx 4
  task automatic render_key2(string name, int er, int eg, int eb);
    set_px(130, 401, 1'b1); tick();
    set_px(0, 0, 1'b0); tick(); tick();
    chk({name, "_hit"}, int'(label_hit), 1);
    chk({name, "_r"}, int'(Red), er);
    chk({name, "_g"}, int'(Green), eg);
    chk({name, "_b"}, int'(Blue), eb);
  endtask

  initial begin
    int k, x, y, hr, hg;
    for (int i = 0; i < NK; i++)
      for (int a = 0; a < DEPTH; a++) mem[i][a] = 4'($urandom);
    mem[0][0]  = 4'd5;
    mem[1][54] = 4'd0;
    mem[2][28] = 4'd4;

    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    // Warm-up stream around key 0 so outputs are non-zero before the reset
    for (int i = 0; i < 20; i++) begin
      set_px(48 + (i % 20), 400 + (i % 7), 1'b1);
      tick();
    end

    // Asynchronous reset mid-stream clears everything at once
    Reset_n = 1'b0;
    #1;
    chk("rst_addr", int'(rom_addr), 0);
    chk("rst_hit", int'(label_hit), 0);
    chk("rst_rgb", int'({Red, Green, Blue}), 0);
    compare_all();
    tick();
    Reset_n = 1'b1;

    // Directed pixels: key0 origin, key1 black offset, right-edge miss, blanked
    set_px(48, 400, 1'b1); tick();
    chk("a_addr", int'(rom_addr), 0);
    set_px(90, 342, 1'b1); tick();
    chk("b_addr", int'(rom_addr), 54);
    set_px(74, 400, 1'b1); tick();
    chk("c_addr", int'(rom_addr), 0);
    chk("a_hit", int'(label_hit), 1);
    chk("a_rgb", int'({Red, Green, Blue}), 24'h555555);
    set_px(48, 400, 1'b0); tick();
    chk("d_addr", int'(rom_addr), 0);
    chk("b_hit", int'(label_hit), 0);
    chk("b_rgb", int'({Red, Green, Blue}), 0);
    set_px(0, 0, 1'b0); tick();
    chk("c_hit", int'(label_hit), 0);
    tick();
    chk("d_hit", int'(label_hit), 0);

`ifdef KEY_LABEL_HILITE_EN
    hr = 8'hFF; hg = 8'h22;
`else
    hr = 8'h44; hg = 8'h44;
`endif
    // One-cycle press then 7 frames: still highlighted; 8th frame clears it
    key_pressed[2] = 1'b1; tick();
    key_pressed[2] = 1'b0; tick();
    repeat (7) frame();
    render_key2("hold7", hr, hg, hg);
    frame();
    render_key2("hold8", 8'h44, 8'h44, 8'h44);

    // Press coincident with frame_start at count 3 reloads the full hold
    key_pressed[2] = 1'b1; tick();
    key_pressed[2] = 1'b0; tick();
    repeat (5) frame();
    key_pressed[2] = 1'b1; frame_start = 1'b1; tick();
    key_pressed[2] = 1'b0; frame_start = 1'b0; tick();
    repeat (7) frame();
    render_key2("reload7", hr, hg, hg);
    frame();
    render_key2("reload8", 8'h44, 8'h44, 8'h44);

    // Randomised stream biased toward label edges
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        Reset_n = 1'b0;
        #1;
        compare_all();
        tick();
        Reset_n = 1'b1;
      end
      if ($urandom_range(0, 3) != 0) begin
        k = int'($urandom_range(0, NK - 1));
        x = lab_x(k) + int'($urandom_range(0, LW + 3)) - 2;
        y = lab_y(k) + int'($urandom_range(0, LH + 3)) - 2;
      end else begin
        x = int'($urandom_range(0, 799));
        y = int'($urandom_range(0, 524));
      end
      set_px(x, y, $urandom_range(0, 9) != 0);
      frame_start = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0)
        key_pressed[$urandom_range(0, NK - 1)] = ~key_pressed[$urandom_range(0, NK - 1)];
      if ($urandom_range(0, 9) == 0) key_pressed = 13'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_label_renderer.md
Name: key_label_renderer

Overview:
- Pixel-pipeline stage directly downstream of the 13 piano-key letter sprite ROMs (A W S E D F T G Y H U J K → C … high C).
- Takes VGA draw coordinates and generates the shared sprite read address.
- Selects the matching ROM's 4-bit palette index and maps it to 24-bit RGB for the colour mapper.
- Keys that are played, or were played recently, get a highlighted label.

Parameters:
- LABEL_W, 26, sprite width in pixels.
- LABEL_H, 33, sprite height in pixels; LABEL_W*LABEL_H = 858 = ROM depth.
- X0, 48, left X of key 0's label.
- PITCH, 40, horizontal spacing between labels.
- WHITE_Y, 400, top Y of white-key labels.
- BLACK_Y, 340, top Y of black-key labels.
- BLACK_MASK, 13'b0_0101_0100_1010, bit k set = key k is black (sits at BLACK_Y).
- HOLD_FRAMES, 8, frames a highlight persists after release.

Ports:
- Clk  in  1  pixel clock.
- Reset_n  in  1  asynchronous active-low reset.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- blank_n  in  1  1 = visible pixel.
- frame_start  in  1  one-cycle pulse per frame (vsync edge).
- key_pressed  in  13  bit k = key k currently held.
- rom_addr  out  19  read address broadcast to all 13 letter ROMs.
- rom_data  in  52  ROM outputs concatenated; bits [4k+3:4k] = key k.
- label_hit  out  1  1 = RGB is valid label pixel (opaque).
- Red  out  8  red.
- Green  out  8  green.
- Blue  out  8  blue.

Behaviour:
- Hit test per key k:
  - lx = X0 + k*PITCH; ly = BLACK_MASK[k] ? BLACK_Y : WHITE_Y.
  - Hit when blank_n && lx ≤ DrawX < lx+LABEL_W && ly ≤ DrawY < ly+LABEL_H.
  - Labels never overlap; if several match, the lowest k wins.
- Stage 1 (registered, 1 cycle after inputs):
  - s1_hit, s1_key[3:0] registered.
  - rom_addr = (DrawY-ly)*LABEL_W + (DrawX-lx), computed at 19 bits, zero-extended.
  - On a miss, rom_addr = 0 and s1_hit = 0.
- The ROMs are combinational, so rom_data corresponds to rom_addr in the same cycle.
- Stage 2 (registered):
  - s2_idx = rom_data[4*s1_key +: 4].
  - s2_hit = s1_hit && (idx != 0); index 0 is transparent.
  - s2_hl = highlight[s1_key].
- Stage 3 (registered outputs); total latency inputs→RGB = 3 cycles, fully pipelined at one pixel per cycle:
  - Normal: R = G = B = {idx,idx}, i.e. idx*0x11.
  - Highlighted: R = 8'hFF, G = B = {idx,idx} >> 1.
  - !s2_hit: label_hit = 0, RGB = 0.
- Highlight state per key:
  - prev_pressed register detects rising edges.
  - hold_cnt[k] is 4 bits wide, sized for HOLD_FRAMES ≤ 15.
  - Rising edge of key_pressed[k]: hold_cnt[k] ← HOLD_FRAMES.
  - Else on frame_start with hold_cnt[k] ≠ 0 and key released: decrement.
  - A rising edge coincident with frame_start: load wins.
  - highlight[k] = key_pressed[k] | (hold_cnt[k] ≠ 0).
  - Counters saturate at 0 and never wrap.
- Reset (asynchronous, any time including mid-frame):
  - All pipeline regs, rom_addr, label_hit, RGB, hold_cnt and prev_pressed go to 0.
  - Valid output resumes 3 cycles after Reset_n deasserts.

Optional Feature:
- KEY_LABEL_HILITE_EN defined: highlight logic as above.
- Undefined: hold counters, edge detect and s2_hl are removed; every label renders with the normal palette; key_pressed and frame_start are ignored.

Test Plan:
- Reset_n=0 mid-stream → all outputs 0 immediately; release, DrawX=48, DrawY=400, blank_n=1 → rom_addr=0 next cycle.
- Drive rom_data[3:0]=5 at that pixel → 3 cycles later label_hit=1, RGB=55/55/55.
- DrawX=90, DrawY=342 (key 1, black) → rom_addr=54; rom_data[7:4]=0 → label_hit=0, RGB=0.
- DrawX=74, DrawY=400 (one past key 0's right edge), and DrawX=48, DrawY=400 with blank_n=0 → rom_addr=0, label_hit=0.
- Pulse key_pressed[2] for 1 cycle, then 7 frame_starts → key-2 pixel of idx 4 renders FF/22/22; after the 8th frame_start it renders 44/44/44.
- Press key 2 coincident with frame_start while hold_cnt=3 → hold_cnt=8, no decrement that cycle.
